// File: rtl/p2sc_stream_serializer.sv
// -----------------------------------------------------------------------------
// p2sc_stream_serializer
//
// Parallel-to-serial stream converter. Words of WIDTH bits are accepted over a
// valid/ready handshake into a one-entry holding buffer, then serialised one
// bit per clock, LSB-first or MSB-first as selected per word. A buffered word
// is loaded into the shifter on the same edge that ends the previous word's
// last bit, so back-to-back words stream with no gap cycles.
//
// Parameters:
//   WIDTH       word width in bits (2..64)
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   p_in         parallel word
//   p_msb        per-word order: 1 = MSB-first, 0 = LSB-first
//   p_valid      p_in / p_msb valid
//   p_ready      holding buffer empty, a word can be accepted
//   flush        synchronous abort of the current and the buffered word
//   sout         serial data bit
//   sout_valid   sout carries a data bit this cycle
//   frame_start  high on the first bit of each word
//   busy         shifter active or holding buffer full
// -----------------------------------------------------------------------------
module p2sc_stream_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] p_in,
    input  logic             p_msb,
    input  logic             p_valid,
    output logic             p_ready,
    input  logic             flush,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] rev_idx;

    logic [WIDTH-1:0] hold_reg;
    logic             hold_msb;
    logic             hold_full;
    logic [WIDTH-1:0] shift_reg;
    logic             shift_msb;

    logic             accept;
    logic             load;

    // Accept depends only on the registered hold_full, so p_ready never
    // combinationally follows p_valid. Accept and load are mutually exclusive
    // because they require opposite values of hold_full.
    assign accept = p_valid & ~hold_full & ~flush;
    assign load   = hold_full & ((state == IDLE) | ((state == SHIFT) & (cnt == LAST)));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; flush overrides both load and normal progression
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (load) begin
            state_nxt = SHIFT;
            cnt_nxt   = '0;
        end else if (state == SHIFT) begin
            if (cnt == LAST) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // Holding buffer and shifter word storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_reg  <= '0;
            hold_msb  <= 1'b0;
            hold_full <= 1'b0;
            shift_reg <= '0;
            shift_msb <= 1'b0;
        end else begin
            if (flush) begin
                hold_full <= 1'b0;
            end else if (load) begin
                hold_full <= 1'b0;
                shift_reg <= hold_reg;
                shift_msb <= hold_msb;
            end else if (accept) begin
                hold_full <= 1'b1;
                hold_reg  <= p_in;
                hold_msb  <= p_msb;
            end
        end
    end

    // The word is indexed rather than shifted: shift_reg stays constant for
    // the whole word and cnt selects the bit from either end.
    assign rev_idx = LAST - cnt;

    // Output logic
    always_comb begin
        sout        = 1'b0;
        sout_valid  = 1'b0;
        frame_start = 1'b0;
        if (state == SHIFT) begin
            sout_valid  = 1'b1;
            frame_start = (cnt == '0);
            sout        = shift_msb ? shift_reg[rev_idx] : shift_reg[cnt];
        end
    end

    assign p_ready = ~hold_full;
    assign busy    = (state == SHIFT) | hold_full;

endmodule

// File: tb/tb_p2sc_stream_serializer.sv
// -----------------------------------------------------------------------------
// Directed testbench for p2sc_stream_serializer (WIDTH = 8).
// Expected bit sequences are packed so that bit i of a constant is the value
// sout must carry on the i-th serial cycle.
// -----------------------------------------------------------------------------
module tb_p2sc_stream_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] p_in;
    logic       p_msb;
    logic       p_valid;
    logic       p_ready;
    logic       flush;
    logic       sout;
    logic       sout_valid;
    logic       frame_start;
    logic       busy;

    int n_cmp;
    int n_bad;

    p2sc_stream_serializer #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .p_in        (p_in),
        .p_msb       (p_msb),
        .p_valid     (p_valid),
        .p_ready     (p_ready),
        .flush       (flush),
        .sout        (sout),
        .sout_valid  (sout_valid),
        .frame_start (frame_start),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one serial cycle: advance, then check the bit against the tables
    task automatic bit_chk(input string tag, input int i, input logic [63:0] seq,
                           input logic [63:0] fs, input logic [63:0] rdy);
        step();
        chk($sformatf("%s.vld%0d", tag, i), {63'd0, sout_valid}, 64'd1);
        chk($sformatf("%s.bit%0d", tag, i), {63'd0, sout}, {63'd0, seq[i]});
        chk($sformatf("%s.fs%0d", tag, i), {63'd0, frame_start}, {63'd0, fs[i]});
        chk($sformatf("%s.rdy%0d", tag, i), {63'd0, p_ready}, {63'd0, rdy[i]});
    endtask

    task automatic idle_chk(input string tag);
        step();
        chk({tag, ".vld"}, {63'd0, sout_valid}, 64'd0);
        chk({tag, ".sout"}, {63'd0, sout}, 64'd0);
        chk({tag, ".fs"}, {63'd0, frame_start}, 64'd0);
        chk({tag, ".busy"}, {63'd0, busy}, 64'd0);
        chk({tag, ".rdy"}, {63'd0, p_ready}, 64'd1);
    endtask

    // present a word for exactly one accepting edge
    task automatic send(input logic [7:0] d, input logic m);
        p_in    = d;
        p_msb   = m;
        p_valid = 1'b1;
        step();
        p_valid = 1'b0;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        p_in    = 8'h00;
        p_msb   = 1'b0;
        p_valid = 1'b0;
        flush   = 1'b0;

        #3;
        chk("rst.rdy", {63'd0, p_ready}, 64'd1);
        chk("rst.vld", {63'd0, sout_valid}, 64'd0);
        chk("rst.sout", {63'd0, sout}, 64'd0);
        chk("rst.fs", {63'd0, frame_start}, 64'd0);
        chk("rst.busy", {63'd0, busy}, 64'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // LSB-first A5: accepted, then loaded one edge later
        send(8'hA5, 1'b0);
        chk("lsb.acc_vld", {63'd0, sout_valid}, 64'd0);
        chk("lsb.acc_rdy", {63'd0, p_ready}, 64'd0);
        chk("lsb.acc_busy", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 8; i++) bit_chk("lsb", i, 64'hA5, 64'h01, 64'hFF);
        idle_chk("lsb.end");

        // MSB-first A5 and 01
        send(8'hA5, 1'b1);
        for (int i = 0; i < 8; i++) bit_chk("msbA5", i, 64'hA5, 64'h01, 64'hFF);
        idle_chk("msbA5.end");
        send(8'h01, 1'b1);
        for (int i = 0; i < 8; i++) bit_chk("msb01", i, 64'h80, 64'h01, 64'hFF);
        idle_chk("msb01.end");

        // back-to-back F0 (LSB) then 3C (MSB), second accepted during bit 2
        send(8'hF0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            bit_chk("b2b", i, 64'h3CF0, 64'h0101, 64'hFF07);
            if (i == 2) begin
                p_in    = 8'h3C;
                p_msb   = 1'b1;
                p_valid = 1'b1;
            end
            if (i == 3) begin
                p_valid = 1'b0;
                p_in    = 8'hFF;
                p_msb   = 1'b0;
            end
        end
        idle_chk("b2b.end");

        // backpressure: 22 buffered while 11 shifts, 77 held valid meanwhile
        send(8'h11, 1'b0);
        for (int i = 0; i < 24; i++) begin
            bit_chk("bp", i, 64'h772211, 64'h010101, 64'hFF0103);
            if (i == 1) begin
                p_in    = 8'h22;
                p_valid = 1'b1;
            end
            if (i == 2) p_in = 8'h77;
            if (i == 9) p_valid = 1'b0;
        end
        idle_chk("bp.end");

        // flush at bit 3 of FF with 00 buffered
        send(8'hFF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bit_chk("fl", i, 64'hFF, 64'h01, 64'h01);
            if (i == 0) begin
                p_in    = 8'h00;
                p_valid = 1'b1;
            end
            if (i == 1) p_valid = 1'b0;
            if (i == 3) flush = 1'b1;
        end
        step();
        flush = 1'b0;
        chk("fl.vld", {63'd0, sout_valid}, 64'd0);
        chk("fl.busy", {63'd0, busy}, 64'd0);
        chk("fl.rdy", {63'd0, p_ready}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("fl.quiet%0d", i), {63'd0, sout_valid}, 64'd0);
        end

        // a word offered together with flush is dropped
        p_in    = 8'h55;
        p_valid = 1'b1;
        flush   = 1'b1;
        step();
        p_valid = 1'b0;
        flush   = 1'b0;
        chk("flacc.rdy", {63'd0, p_ready}, 64'd1);
        chk("flacc.busy", {63'd0, busy}, 64'd0);
        idle_chk("flacc.after");

        // async reset during bit 2 of A5 (sout=1 there), between clock edges
        send(8'hA5, 1'b0);
        for (int i = 0; i < 3; i++) bit_chk("ar", i, 64'hA5, 64'h01, 64'hFF);
        #2;
        rst = 1'b1;
        #1;
        chk("ar.vld", {63'd0, sout_valid}, 64'd0);
        chk("ar.fs", {63'd0, frame_start}, 64'd0);
        chk("ar.busy", {63'd0, busy}, 64'd0);
        chk("ar.sout", {63'd0, sout}, 64'd0);
        chk("ar.rdy", {63'd0, p_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("ar.quiet%0d", i), {63'd0, sout_valid}, 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
